cursor_report_packer: RTL and testbench
=======================================

CURSOR_REPORT_PACKER -- requirements
Module: cursor_report_packer

Interface
REQ-001 Parameter REPORT_DIV, default 16'd1000, clk cycles per report interval (legal range 2..65535).
REQ-002 Parameter ACC_LIM, default 16'sd32767, accumulator saturation magnitude per axis.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sample_en  input  1  qualifies dx/dy/buttons for one cycle.
REQ-006 dx  input  8 signed  per-sample X motion from the cursor mapping stage.
REQ-007 dy  input  8 signed  per-sample Y motion from the cursor mapping stage.
REQ-008 buttons  input  3  button state {middle, right, left}.
REQ-009 m_data  output  8  packet byte.
REQ-010 m_valid  output  1  m_data valid.
REQ-011 m_ready  input  1  sink accepts byte when high with m_valid.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 Per axis, a 16-bit signed accumulator SHALL add dx/dy on each sample_en cycle, saturating at +ACC_LIM / -ACC_LIM.
REQ-014 Interval counter SHALL count 0..REPORT_DIV-1 and wrap; the wrap cycle sets report_due.
REQ-015 report_due SHALL be a single pending flag: further wraps while set are not queued.
REQ-016 FSM states: IDLE, HDR, XB, YB.
REQ-017 In IDLE with report_due set, if acc_x==0, acc_y==0 and buttons==last_buttons, clear report_due and remain IDLE (no packet).
REQ-018 Otherwise, in that same cycle: latch px=clamp(acc_x,-127,+127), py=clamp(acc_y,-127,+127), xov=(|acc_x|>127), yov=(|acc_y|>127), pb=buttons; set last_buttons=buttons; clear report_due; go to HDR.
REQ-019 Residual carry: on latch, acc SHALL become acc-px (+dx if sample_en same cycle), likewise Y; motion beyond the clamp is delivered in later reports.
REQ-020 Header byte SHALL be {yov, xov, py[7], px[7], 1'b1, pb[2:0]}; Y sign convention passes through unchanged.
REQ-021 HDR, XB, YB SHALL drive m_valid=1 with m_data = header, px, py respectively; advance only on m_valid&&m_ready; YB acceptance returns to IDLE.
REQ-022 m_data SHALL be held stable while m_valid&&!m_ready.
REQ-023 Latency: first byte valid the cycle after the latching IDLE edge; minimum 3 cycles per packet with m_ready held high.
REQ-024 Accumulation and interval counting SHALL continue during HDR/XB/YB.
REQ-025 m_valid SHALL be 0 in IDLE.

Reset
REQ-026 On rst: FSM=IDLE, m_valid=0, m_data=0, busy=0, acc_x=acc_y=0, counter=0, report_due=0, last_buttons=0, latched px/py/pb/ovf=0.
REQ-027 Reset mid-packet SHALL drop m_valid immediately (asynchronously) and discard the packet; no partial completion after release.

Structure
REQ-028 Shared package cursor_pkg SHALL hold FSM state encoding, header bit positions, REPORT_BYTES=3 and PKT_CLAMP=127.
REQ-029 One sub-module sat_accum16 (saturating signed add plus residual subtract), instantiated per axis.

Verification
REQ-030 REPORT_DIV=4, dx=+3 dy=-2 on 4 sample_en cycles, m_ready=1 -> bytes 0x28, 0x0C, 0xF8.
REQ-031 acc_x accumulated to +300, dy=0 -> packet px=0x7F, xov=1, header 0x48; next report px=0x7F; third px=0x2E (46), xov=0.
REQ-032 No motion, buttons unchanged across 3 intervals -> m_valid never asserts; then left button pressed -> header 0x09, px=py=0.
REQ-033 m_ready low 10 cycles during XB -> m_data holds 0x0C-style value stable, m_valid held; two interval wraps during stall yield exactly one following packet.
REQ-034 dx=+127 on 300 consecutive samples -> acc_x saturates at 32767, no wrap to negative.
REQ-035 rst asserted during XB -> m_valid 0 same cycle, busy 0, accumulators 0, first post-reset packet only after a new full interval.

Source files
------------

// File: rtl/cursor_pkg.sv
// Shared definitions for the cursor report packer: FSM encoding, header layout
// and packet clamp helpers.
package cursor_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_XB   = 2'd2;
    localparam logic [1:0] ST_YB   = 2'd3;

    localparam int unsigned HDR_BTN_LSB = 0;
    localparam int unsigned HDR_ONE     = 3;
    localparam int unsigned HDR_XSGN    = 4;
    localparam int unsigned HDR_YSGN    = 5;
    localparam int unsigned HDR_XOV     = 6;
    localparam int unsigned HDR_YOV     = 7;

    localparam int unsigned REPORT_BYTES = 3;
    localparam int          PKT_CLAMP    = 127;

    function automatic logic [7:0] clamp_pkt(input logic signed [15:0] v);
        if (v > 16'(PKT_CLAMP))
            return 8'(PKT_CLAMP);
        else if (v < -16'(PKT_CLAMP))
            return 8'(-PKT_CLAMP);
        else
            return v[7:0];
    endfunction

    function automatic logic over_pkt(input logic signed [15:0] v);
        return (v > 16'(PKT_CLAMP)) || (v < -16'(PKT_CLAMP));
    endfunction

endpackage

// File: rtl/sat_accum16.sv
// Per-axis 16-bit signed accumulator: optional residual subtract and sample add,
// saturating at +/-ACC_LIM.
module sat_accum16 #(
    parameter logic signed [15:0] ACC_LIM = 16'sd32767
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               add_en,
    input  logic signed [7:0]  add_val,
    input  logic               sub_en,
    input  logic signed [7:0]  sub_val,
    output logic signed [15:0] acc
);

    localparam logic signed [17:0] LIM18 = {{2{ACC_LIM[15]}}, ACC_LIM};

    logic signed [17:0] sum;
    logic signed [15:0] acc_nxt;

    // 18 bits hold acc - sub + add without overflow before the clamp.
    always_comb begin
        sum = {{2{acc[15]}}, acc};
        if (sub_en)
            sum = sum - {{10{sub_val[7]}}, sub_val};
        if (add_en)
            sum = sum + {{10{add_val[7]}}, add_val};
        if (sum > LIM18)
            acc_nxt = ACC_LIM;
        else if (sum < -LIM18)
            acc_nxt = -ACC_LIM;
        else
            acc_nxt = sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else
            acc <= acc_nxt;
    end

endmodule

// File: rtl/cursor_report_packer.sv
// Accumulates cursor motion and periodically emits a 3-byte report
// (header, X, Y) over a valid/ready byte stream.
module cursor_report_packer
    import cursor_pkg::*;
#(
    parameter logic [15:0]        REPORT_DIV = 16'd1000,
    parameter logic signed [15:0] ACC_LIM    = 16'sd32767
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic signed [7:0] dx,
    input  logic signed [7:0] dy,
    input  logic [2:0]        buttons,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy
);

    logic [1:0]         state;
    logic [15:0]        cnt;
    logic               report_due;
    logic [2:0]         last_buttons;
    logic [7:0]         px, py;
    logic               xov, yov;
    logic [2:0]         pb;
    logic signed [15:0] acc_x, acc_y;
    logic               idle, wrap, quiet, latch, accept;
    logic [7:0]         hdr;

    assign idle    = (state == ST_IDLE);
    assign wrap    = (cnt == REPORT_DIV - 16'd1);
    assign quiet   = (acc_x == '0) && (acc_y == '0) && (buttons == last_buttons);
    assign latch   = idle && report_due && !quiet;
    assign m_valid = !idle;
    assign busy    = !idle;
    assign accept  = m_valid && m_ready;

    sat_accum16 #(.ACC_LIM(ACC_LIM)) u_acc_x (
        .clk     (clk),
        .rst     (rst),
        .add_en  (sample_en),
        .add_val (dx),
        .sub_en  (latch),
        .sub_val (clamp_pkt(acc_x)),
        .acc     (acc_x)
    );

    sat_accum16 #(.ACC_LIM(ACC_LIM)) u_acc_y (
        .clk     (clk),
        .rst     (rst),
        .add_en  (sample_en),
        .add_val (dy),
        .sub_en  (latch),
        .sub_val (clamp_pkt(acc_y)),
        .acc     (acc_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            report_due <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 16'd1;
            // A wrap coinciding with consumption starts a fresh interval, so set wins.
            if (wrap)
                report_due <= 1'b1;
            else if (idle && report_due)
                report_due <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            last_buttons <= '0;
            px           <= '0;
            py           <= '0;
            xov          <= 1'b0;
            yov          <= 1'b0;
            pb           <= '0;
        end else begin
            case (state)
                ST_IDLE: if (latch) begin
                    px           <= clamp_pkt(acc_x);
                    py           <= clamp_pkt(acc_y);
                    xov          <= over_pkt(acc_x);
                    yov          <= over_pkt(acc_y);
                    pb           <= buttons;
                    last_buttons <= buttons;
                    state        <= ST_HDR;
                end
                ST_HDR:  if (accept) state <= ST_XB;
                ST_XB:   if (accept) state <= ST_YB;
                ST_YB:   if (accept) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        hdr                       = '0;
        hdr[HDR_BTN_LSB +: 3]     = pb;
        hdr[HDR_ONE]              = 1'b1;
        hdr[HDR_XSGN]             = px[7];
        hdr[HDR_YSGN]             = py[7];
        hdr[HDR_XOV]              = xov;
        hdr[HDR_YOV]              = yov;
        case (state)
            ST_HDR:  m_data = hdr;
            ST_XB:   m_data = px;
            ST_YB:   m_data = py;
            default: m_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cursor_report_packer.sv
// Randomized scoreboard bench for cursor_report_packer against a cycle-level
// behavioural model of accumulation, interval timing and packet contents.
module tb_cursor_report_packer;

    localparam int DIV = 4;
    localparam int LIM = 32767;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_en;
    logic signed [7:0] dx, dy;
    logic [2:0]        buttons;
    logic [7:0]        m_data;
    logic              m_valid;
    logic              m_ready;
    logic              busy;

    cursor_report_packer #(.REPORT_DIV(16'd4), .ACC_LIM(16'sd32767)) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .dx        (dx),
        .dy        (dy),
        .buttons   (buttons),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] expq[$];
    int         ax, ay, mcnt, left;
    bit         due;
    logic [2:0] lastb;

    function automatic int sat(input int v);
        if (v > LIM) return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    function automatic int clp(input int v);
        if (v > 127) return 127;
        if (v < -127) return -127;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ax = 0; ay = 0; mcnt = 0; left = 0; due = 0; lastb = '0;
        expq.delete();
    endtask

    // One clock of the reference: packet progress as a byte count, motion as integers.
    task automatic model_step();
        int px, py;
        logic [7:0] bx, by, hdr;
        px = 0; py = 0;
        if (left > 0) begin
            if (m_ready) left--;
        end else if (due) begin
            due = 0;
            if (!(ax == 0 && ay == 0 && buttons == lastb)) begin
                px = clp(ax);
                py = clp(ay);
                bx = px[7:0];
                by = py[7:0];
                hdr = {(ay > 127 || ay < -127), (ax > 127 || ax < -127), by[7], bx[7], 1'b1, buttons};
                expq.push_back(hdr);
                expq.push_back(bx);
                expq.push_back(by);
                left = 3;
                lastb = buttons;
            end
        end
        ax = sat(ax - px + (sample_en ? int'(dx) : 0));
        ay = sat(ay - py + (sample_en ? int'(dy) : 0));
        if (mcnt == DIV - 1) begin
            mcnt = 0;
            due = 1;
        end else begin
            mcnt++;
        end
    endtask

    task automatic cyc(input logic en, input int vx, input int vy, input logic [2:0] b, input logic rdy);
        sample_en = en;
        dx = 8'(vx);
        dy = 8'(vy);
        buttons = b;
        m_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_valid", 32'(m_valid), 32'(left > 0));
            chk("busy", 32'(busy), 32'(left > 0));
            if (m_valid) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0h expected none at %0t", m_data, $time);
                end else begin
                    chk("m_data", 32'(m_data), 32'(expq[0]));
                    if (m_ready) void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        sample_en = 1'b0; dx = '0; dy = '0; buttons = '0; m_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Small motion: +3/-2 over one interval.
        for (int i = 0; i < 4; i++) cyc(1'b1, 3, -2, 3'b000, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 0, 0, 3'b000, 1'b1);

        // Large X motion exceeding the clamp, drained over several reports.
        for (int i = 0; i < 3; i++) cyc(1'b1, 100, 0, 3'b000, 1'b0);
        for (int i = 0; i < 24; i++) cyc(1'b0, 0, 0, 3'b000, 1'b1);

        // Quiet intervals, then a left-button press.
        for (int i = 0; i < 14; i++) cyc(1'b0, 0, 0, 3'b000, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 0, 0, 3'b001, 1'b1);

        // Stall during the X byte across two interval wraps.
        for (int i = 0; i < 4; i++) cyc(1'b1, 3, -2, 3'b001, 1'b1);
        n = 0;
        while (left != 2 && n < 40) begin
            cyc(1'b0, 0, 0, 3'b001, 1'b1);
            n++;
        end
        chk("reach_xb", 32'(left), 32'd2);
        for (int i = 0; i < 10; i++) cyc(1'b0, 0, 0, 3'b001, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 0, 0, 3'b001, 1'b1);

        // Saturation: 300 samples of +127 while the sink blocks.
        for (int i = 0; i < 300; i++) cyc(1'b1, 127, 0, 3'b001, 1'b0);
        chk("acc_x_sat", 32'(dut.u_acc_x.acc), 32'(16'sd32767));
        for (int i = 0; i < 60; i++) cyc(1'b0, 0, 0, 3'b001, 1'b1);

        // Random traffic.
        for (int i = 0; i < 500; i++)
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 255)) - 128, 3'($urandom_range(0, 7)),
                ($urandom_range(0, 3) != 0));

        // Reset while the X byte is presented.
        n = 0;
        while (left != 2 && n < 200) begin
            cyc(1'b1, 20, -20, 3'b010, 1'b1);
            n++;
        end
        chk("reach_xb2", 32'(left), 32'd2);
        rst = 1'b1;
        #1;
        chk("rst_mid_m_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_acc_x", 32'(dut.u_acc_x.acc), 32'd0);
        chk("rst_mid_acc_y", 32'(dut.u_acc_y.acc), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) cyc(1'b1, 5, 7, 3'b100, 1'b1);

        for (int i = 0; i < 150; i++)
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 60)) - 30,
                int'($urandom_range(0, 60)) - 30, 3'($urandom_range(0, 7)),
                ($urandom_range(0, 2) != 0));

        n = 0;
        while ((expq.size() != 0 || left != 0 || ax != 0 || ay != 0) && n < 3000) begin
            cyc(1'b0, 0, 0, 3'b000, 1'b1);
            n++;
        end
        chk("drain_queue", 32'(expq.size()), 32'd0);
        chk("drain_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
